// File: rtl/demux_router.sv
// demux_router: registered 1-to-N demultiplexer. Each destination owns a
// one-entry holding slot with valid/ready flow control, so slots drain independently.
module demux_router #(
  parameter  int OUTPUTS = 2,
  localparam int SW      = $clog2(OUTPUTS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  input  logic [SW-1:0] in_sel,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [31:0]   out0_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [31:0]   out1_data,
  output logic          out2_valid,
  input  logic          out2_ready,
  output logic [31:0]   out2_data,
  output logic          sel_err,
  input  logic          err_clr
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_t;

  localparam int unsigned NSLOT     = 3;
  localparam int unsigned OUTPUTS_U = OUTPUTS;
  localparam logic [1:0]  LP_NOUT   = 2'(OUTPUTS);

  slot_state_t r_state     [NSLOT];
  slot_state_t w_state_nxt [NSLOT];
  logic [31:0] r_data      [NSLOT];
  logic        w_ready     [NSLOT];
  logic        w_load      [NSLOT];
  logic        r_sel_err;
  logic [1:0]  w_sel;
  logic [1:0]  w_eff;
  logic        w_bad_sel;
  logic        w_accept;

  // Out-of-range selects fall back to slot 0 and raise the sticky error.
  assign w_sel     = 2'(in_sel);
  assign w_bad_sel = (w_sel >= LP_NOUT);
  assign w_eff     = w_bad_sel ? 2'd0 : w_sel;

  assign w_ready[0] = out0_ready;
  assign w_ready[1] = out1_ready;
  assign w_ready[2] = (OUTPUTS == 3) & out2_ready;

  always_comb begin
    in_ready = 1'b0;
    case (w_eff)
      2'd1:    in_ready = (r_state[1] == S_EMPTY) || w_ready[1];
      2'd2:    in_ready = (r_state[2] == S_EMPTY) || w_ready[2];
      default: in_ready = (r_state[0] == S_EMPTY) || w_ready[0];
    endcase
  end

  assign w_accept = in_valid & in_ready;

  always_comb begin
    for (int unsigned k = 0; k < NSLOT; k++) begin
      w_load[k]      = 1'b0;
      w_state_nxt[k] = S_EMPTY;
      if (k < OUTPUTS_U) begin
        w_load[k]      = w_accept && (w_eff == 2'(k));
        w_state_nxt[k] = r_state[k];
        case (r_state[k])
          S_EMPTY: if (w_load[k]) w_state_nxt[k] = S_FULL;
          S_FULL:  if (!w_load[k] && w_ready[k]) w_state_nxt[k] = S_EMPTY;
          default: w_state_nxt[k] = S_EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NSLOT; k++) begin
        r_state[k] <= S_EMPTY;
        r_data[k]  <= '0;
      end
      r_sel_err <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NSLOT; k++) begin
        r_state[k] <= w_state_nxt[k];
        if (w_load[k]) r_data[k] <= in_data;
      end
      if (w_accept && w_bad_sel) r_sel_err <= 1'b1;
      else if (err_clr)          r_sel_err <= 1'b0;
    end
  end

  assign out0_valid = (r_state[0] == S_FULL);
  assign out0_data  = r_data[0];
  assign out1_valid = (r_state[1] == S_FULL);
  assign out1_data  = r_data[1];
  assign out2_valid = (OUTPUTS == 3) && (r_state[2] == S_FULL);
  assign out2_data  = (OUTPUTS == 3) ? r_data[2] : '0;
  assign sel_err    = r_sel_err;

endmodule

// File: tb/tb_demux_router.sv
// Bench for demux_router: directed vector table on a 3-port instance, async reset
// sequence, and a random stream on 2- and 3-port instances against a queue scoreboard.
module tb_demux_router;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Index 0 drives the OUTPUTS=2 instance, index 1 the OUTPUTS=3 instance.
  logic        in_v [2];
  logic [1:0]  in_s [2];
  logic [31:0] in_d [2];
  logic [2:0]  o_r  [2];
  logic        clr  [2];
  logic        ir   [2];
  logic        ovl  [2][3];
  logic [31:0] od   [2][3];
  logic        err  [2];

  int n_cmp = 0;
  int n_bad = 0;

  demux_router #(.OUTPUTS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_v[0]), .in_ready(ir[0]), .in_data(in_d[0]), .in_sel(in_s[0][0:0]),
    .out0_valid(ovl[0][0]), .out0_ready(o_r[0][0]), .out0_data(od[0][0]),
    .out1_valid(ovl[0][1]), .out1_ready(o_r[0][1]), .out1_data(od[0][1]),
    .out2_valid(ovl[0][2]), .out2_ready(o_r[0][2]), .out2_data(od[0][2]),
    .sel_err(err[0]), .err_clr(clr[0])
  );

  demux_router #(.OUTPUTS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_v[1]), .in_ready(ir[1]), .in_data(in_d[1]), .in_sel(in_s[1]),
    .out0_valid(ovl[1][0]), .out0_ready(o_r[1][0]), .out0_data(od[1][0]),
    .out1_valid(ovl[1][1]), .out1_ready(o_r[1][1]), .out1_data(od[1][1]),
    .out2_valid(ovl[1][2]), .out2_ready(o_r[1][2]), .out2_data(od[1][2]),
    .sel_err(err[1]), .err_clr(clr[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    int unsigned rep;
    logic        v;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [2:0]  rdy;
    logic        clr;
    logic        e_ir;
    logic [2:0]  e_val;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int unsigned rep, input logic v, input logic [1:0] sel,
                              input logic [31:0] data, input logic [2:0] rdy, input logic c,
                              input logic e_ir, input logic [2:0] e_val, input logic [31:0] e_d0,
                              input logic [31:0] e_d1, input logic [31:0] e_d2, input logic e_err);
    vec_t t;
    t.rep = rep; t.v = v; t.sel = sel; t.data = data; t.rdy = rdy; t.clr = c;
    t.e_ir = e_ir; t.e_val = e_val; t.e_d0 = e_d0; t.e_d1 = e_d1; t.e_d2 = e_d2; t.e_err = e_err;
    return t;
  endfunction

  // Scoreboard: words accepted but not yet consumed, per instance and port (index d*3+k).
  typedef logic [31:0] wq_t [$];
  wq_t         q [6];
  logic        err_m [2];
  int unsigned nout  [2];
  int unsigned acc_n [2];

  task automatic model_step(input int d);
    int unsigned eff;
    logic        exp_ir;
    eff = (32'(in_s[d]) < nout[d]) ? 32'(in_s[d]) : 0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rand.d%0d.out%0d_valid", d, k), 32'(ovl[d][k]), 32'(q[d*3+k].size() != 0));
      if (q[d*3+k].size() != 0)
        chk($sformatf("rand.d%0d.out%0d_data", d, k), od[d][k], q[d*3+k][0]);
    end
    if (d == 0) chk("rand.d0.out2_data_zero", od[0][2], 32'h0);
    exp_ir = (q[d*3+int'(eff)].size() == 0) || o_r[d][eff];
    chk($sformatf("rand.d%0d.in_ready", d), 32'(ir[d]), 32'(exp_ir));
    chk($sformatf("rand.d%0d.sel_err", d), 32'(err[d]), 32'(err_m[d]));
    for (int k = 0; k < 3; k++)
      if (q[d*3+k].size() != 0 && o_r[d][k]) void'(q[d*3+k].pop_front());
    if (in_v[d] && exp_ir) begin
      q[d*3+int'(eff)].push_back(in_d[d]);
      acc_n[d]++;
    end
    if (in_v[d] && exp_ir && 32'(in_s[d]) >= nout[d]) err_m[d] = 1'b1;
    else if (clr[d])                                  err_m[d] = 1'b0;
  endtask

  initial begin
    int unsigned cyc;
    nout[0] = 2; nout[1] = 3;
    for (int d = 0; d < 2; d++) begin
      in_v[d] = 1'b0; in_s[d] = 2'd0; in_d[d] = '0; o_r[d] = '0; clr[d] = 1'b0;
      err_m[d] = 1'b0; acc_n[d] = 0;
    end

    // Reset state
    #2;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("reset.d%0d.out%0d_valid", d, k), 32'(ovl[d][k]), 32'h0);
        chk($sformatf("reset.d%0d.out%0d_data", d, k), od[d][k], 32'h0);
      end
      chk($sformatf("reset.d%0d.sel_err", d), 32'(err[d]), 32'h0);
      chk($sformatf("reset.d%0d.in_ready", d), 32'(ir[d]), 32'h1);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors on the 3-port instance; expectations are after the edge.
    tbl.push_back(mk(1, 1, 2'd1, 32'hDEADBEEF, 3'b000, 0, 1, 3'b010, 32'h0,  32'hDEADBEEF, 32'h0,  0));
    tbl.push_back(mk(5, 0, 2'd0, 32'h0,        3'b000, 0, 1, 3'b010, 32'h0,  32'hDEADBEEF, 32'h0,  0));
    tbl.push_back(mk(2, 1, 2'd1, 32'h1,        3'b000, 0, 0, 3'b010, 32'h0,  32'hDEADBEEF, 32'h0,  0));
    tbl.push_back(mk(1, 1, 2'd1, 32'h1,        3'b010, 0, 1, 3'b010, 32'h0,  32'h1,        32'h0,  0));
    tbl.push_back(mk(1, 1, 2'd0, 32'hA0,       3'b001, 0, 1, 3'b011, 32'hA0, 32'h1,        32'h0,  0));
    tbl.push_back(mk(1, 1, 2'd0, 32'hA1,       3'b001, 0, 1, 3'b011, 32'hA1, 32'h1,        32'h0,  0));
    tbl.push_back(mk(1, 1, 2'd0, 32'hA2,       3'b001, 0, 1, 3'b011, 32'hA2, 32'h1,        32'h0,  0));
    tbl.push_back(mk(1, 0, 2'd0, 32'h0,        3'b001, 0, 1, 3'b010, 32'hA2, 32'h1,        32'h0,  0));
    tbl.push_back(mk(1, 1, 2'd3, 32'h55,       3'b000, 0, 1, 3'b011, 32'h55, 32'h1,        32'h0,  1));
    tbl.push_back(mk(1, 0, 2'd0, 32'h0,        3'b000, 1, 0, 3'b011, 32'h55, 32'h1,        32'h0,  0));
    tbl.push_back(mk(1, 1, 2'd3, 32'h66,       3'b001, 1, 1, 3'b011, 32'h66, 32'h1,        32'h0,  1));
    tbl.push_back(mk(1, 0, 2'd0, 32'h0,        3'b001, 0, 1, 3'b010, 32'h66, 32'h1,        32'h0,  1));
    tbl.push_back(mk(1, 1, 2'd2, 32'h77,       3'b000, 0, 1, 3'b110, 32'h66, 32'h1,        32'h77, 1));
    tbl.push_back(mk(1, 1, 2'd0, 32'h88,       3'b000, 0, 1, 3'b111, 32'h88, 32'h1,        32'h77, 1));
    tbl.push_back(mk(1, 1, 2'd2, 32'h99,       3'b000, 0, 0, 3'b111, 32'h88, 32'h1,        32'h77, 1));
    tbl.push_back(mk(1, 0, 2'd0, 32'h0,        3'b111, 0, 1, 3'b000, 32'h88, 32'h1,        32'h77, 1));
    tbl.push_back(mk(1, 0, 2'd0, 32'h0,        3'b000, 1, 1, 3'b000, 32'h88, 32'h1,        32'h77, 0));

    foreach (tbl[i]) begin
      for (int unsigned r = 0; r < tbl[i].rep; r++) begin
        in_v[1] = tbl[i].v; in_s[1] = tbl[i].sel; in_d[1] = tbl[i].data;
        o_r[1]  = tbl[i].rdy; clr[1] = tbl[i].clr;
        @(negedge clk);
        chk($sformatf("tbl%0d.%0d.in_ready", i, r), 32'(ir[1]), 32'(tbl[i].e_ir));
        @(posedge clk); #1;
        chk($sformatf("tbl%0d.%0d.valid", i, r), 32'({ovl[1][2], ovl[1][1], ovl[1][0]}), 32'(tbl[i].e_val));
        chk($sformatf("tbl%0d.%0d.out0_data", i, r), od[1][0], tbl[i].e_d0);
        chk($sformatf("tbl%0d.%0d.out1_data", i, r), od[1][1], tbl[i].e_d1);
        chk($sformatf("tbl%0d.%0d.out2_data", i, r), od[1][2], tbl[i].e_d2);
        chk($sformatf("tbl%0d.%0d.sel_err", i, r), 32'(err[1]), 32'(tbl[i].e_err));
      end
    end

    // Asynchronous reset with slot 0 holding a word
    in_v[1] = 1'b1; in_s[1] = 2'd0; in_d[1] = 32'hCAFE; o_r[1] = 3'b000; clr[1] = 1'b0;
    @(posedge clk); #1;
    in_v[1] = 1'b0;
    chk("arst.pre.out0_valid", 32'(ovl[1][0]), 32'h1);
    chk("arst.pre.out0_data", od[1][0], 32'hCAFE);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out0_valid", 32'(ovl[1][0]), 32'h0);
    chk("arst.out0_data", od[1][0], 32'h0);
    chk("arst.out1_data", od[1][1], 32'h0);
    chk("arst.out2_data", od[1][2], 32'h0);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("arst.post.in_ready", 32'(ir[1]), 32'h1);
    chk("arst.post.out0_valid", 32'(ovl[1][0]), 32'h0);
    @(posedge clk); #1;

    // Random stream on both instances until each has accepted at least 100 words
    cyc = 0;
    while ((acc_n[0] < 100 || acc_n[1] < 100) && cyc < 3000) begin
      for (int d = 0; d < 2; d++) begin
        in_v[d] = ($urandom_range(0, 3) != 0);
        in_s[d] = (d == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
        in_d[d] = $urandom;
        o_r[d]  = 3'($urandom_range(0, 7));
        clr[d]  = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      model_step(0);
      model_step(1);
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 3000) chk("rand.cycle_budget", cyc, 32'h0);

    // Drain everything and confirm the slots empty out
    for (int n = 0; n < 2; n++) begin
      for (int d = 0; d < 2; d++) begin
        in_v[d] = 1'b0; o_r[d] = 3'b111; clr[d] = 1'b0;
      end
      @(negedge clk);
      model_step(0);
      model_step(1);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux_router.md
Name: demux_router

Overview:
- Registered 1-to-N demultiplexer: the inverse of the datapath select mux.
- Accepts one 32-bit word per handshake and steers it, by a select code, to one of 2 or 3 destination ports.
- Each destination has a one-entry holding register with valid/ready flow control.
- Sits between result-producing stages and their consumers (writeback, memory, branch units) so a stalled consumer does not block the others once they hold data.

Parameters:
OUTPUTS, 2, number of destination ports; legal values 2 or 3 only; SW = $clog2(OUTPUTS)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  source presents a word
in_ready  output  1  router accepts the word this cycle
in_data  input  32  word to route
in_sel  input  SW  destination index
out0_valid  output  1  slot 0 holds a word
out0_ready  input  1  consumer 0 takes the word
out0_data  output  32  slot 0 word
out1_valid  output  1  slot 1 holds a word
out1_ready  input  1  consumer 1 takes the word
out1_data  output  32  slot 1 word
out2_valid  output  1  slot 2 holds a word; constant 0 when OUTPUTS=2
out2_ready  input  1  consumer 2 takes the word; ignored when OUTPUTS=2
out2_data  output  32  slot 2 word; constant 0 when OUTPUTS=2
sel_err  output  1  sticky: a select value >= OUTPUTS was accepted
err_clr  input  1  synchronous clear of sel_err

Behaviour:
- Reset (rst_n low, asynchronous): all slots EMPTY; outK_valid=0; outK_data=32'h0; sel_err=0. Any in-flight word is discarded.
- Per-slot FSM, two states:
  - EMPTY -> FULL on accept to that slot.
  - FULL -> EMPTY on outK_valid & outK_ready with no accept to that slot in the same cycle.
  - FULL -> FULL when drain and accept to that slot coincide; the new word replaces the old one.
- Effective select: eff = in_sel when in_sel < OUTPUTS, otherwise 0. This only matters for OUTPUTS=3 with in_sel=2'b11.
- in_ready is combinational: high when slot[eff] is EMPTY, or slot[eff] is FULL and outEFF_ready=1. It does not depend on in_valid.
- Accept = in_valid & in_ready at a rising edge. From the next cycle, out[eff]_data = in_data and out[eff]_valid=1. Latency is 1 cycle.
- outK_data holds stable while outK_valid=1 and outK_ready=0. It retains its last value when the slot is EMPTY; it is not cleared.
- Slots are independent: a stalled slot 1 never blocks accepts to slot 0 or slot 2.
- Full throughput: one word per cycle into one slot, provided that slot's consumer holds ready=1.
- sel_err:
  - Set on an accept with in_sel >= OUTPUTS.
  - Cleared by err_clr=1.
  - If set and clear coincide, set wins.
  - sel_err is registered (visible the cycle after the accept).
- in_sel and in_data are sampled only on accept; values while in_valid=0 are don't-care.
- Reset asserted mid-transfer: a word held in a FULL slot is lost. The source must re-send after reset deassertion.

Test Plan:
1. Reset, then in_valid=1, in_sel=1, in_data=32'hDEADBEEF with out1_ready=0 -> in_ready=1. Next cycle out1_valid=1, out1_data=32'hDEADBEEF, out0_valid=0. Values hold for 5 stalled cycles.
2. Slot 1 FULL and stalled; send sel=1, data=32'h1 -> in_ready=0, no state change. Raise out1_ready -> in_ready=1 the same cycle; next cycle out1_data=32'h1 and out1_valid stays 1.
3. Slot 1 stalled FULL; send sel=0 words 32'hA0, 32'hA1, 32'hA2 back-to-back with out0_ready=1 -> in_ready=1 every cycle; out0_data sequence is A0, A1, A2 on consecutive cycles.
4. OUTPUTS=3, in_sel=2'b11, data=32'h55 -> word appears on out0; sel_err=1 the next cycle. err_clr pulse -> sel_err=0. err_clr coinciding with another bad select -> sel_err stays 1.
5. OUTPUTS=2: the out2 ports stay 0 throughout a 100-word random-select stream. A scoreboard confirms per-port in-order delivery and no loss or duplication under random ready.
6. Slot 0 FULL with 32'hCAFE; assert rst_n=0 between clock edges -> out0_valid=0 and out0_data=0 immediately, without waiting for a clock edge; in_ready=1 after release.
